// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes (a - b) mod 2^WIDTH one bit per clock, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start; diff/borrow_out hold the last result
// SHIFT | processing one operand bit per clock (busy=1)
// DONE  | one-cycle result-valid pulse; start here begins the next operation
module serial_sub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             br;
   logic [CW-1:0]    cnt;
   logic             a_bit;
   logic             b_bit;
   logic             d_bit;
   logic             br_nxt;
   logic             last_bit;
   logic             accept;

   assign a_bit    = a_reg[cnt];
   assign b_bit    = b_reg[cnt];
   assign d_bit    = a_bit ^ b_bit ^ br;
   assign br_nxt   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
   assign last_bit = (cnt == CW'(WIDTH - 1));
   // start is only honoured outside SHIFT, so an in-flight operation is never disturbed
   assign accept   = start && (state != SHIFT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (last_bit) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = start ? SHIFT : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg      <= '0;
         b_reg      <= '0;
         br         <= 1'b0;
         cnt        <= '0;
         diff       <= '0;
         borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf        <= 1'b0;
`endif
      end else if (accept) begin
         a_reg <= a;
         b_reg <= b;
         br    <= 1'b0;
         cnt   <= '0;
      end else if (state == SHIFT) begin
         br   <= br_nxt;
         cnt  <= cnt + CW'(1);
         // result enters at the MSB so it lands in natural order after WIDTH shifts
         diff <= {d_bit, diff[WIDTH-1:1]};
         if (last_bit) begin
            borrow_out <= br_nxt;
`ifdef SERIAL_SUB_OVF_EN
            ovf        <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (d_bit != a_reg[WIDTH-1]);
`endif
         end
      end
   end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=8): directed table, random vects vs arithmetic model,
// and hand-written sequences for start-while-busy, back-to-back and mid-operation reset.
module tb_serial_sub;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   int vectors;
   int errors;

   serial_sub #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf        (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic [W-1:0] exp_diff;
      logic         exp_borrow;
      logic         exp_ovf;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: plain unsigned/signed arithmetic
   function automatic logic [W-1:0] m_diff(input logic [W-1:0] x, input logic [W-1:0] y);
      int r;
      r = (int'(x) - int'(y) + 256) % 256;
      return r[W-1:0];
   endfunction

   function automatic logic m_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
      return int'(x) < int'(y);
   endfunction

   function automatic logic m_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
      int sx, sy, r;
      sx = x[W-1] ? int'(x) - 256 : int'(x);
      sy = y[W-1] ? int'(y) - 256 : int'(y);
      r  = sx - sy;
      return (r > 127) || (r < -128);
   endfunction

   // Called at a negedge; returns at the negedge where done is seen (start low).
   task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] ed, input logic eb, input logic eo,
                        input string name);
      int k;
      int busy_cnt;
      start    = 1'b1;
      a        = va;
      b        = vb;
      busy_cnt = 0;
      k        = 0;
      while (k < 30) begin
         @(negedge clk);
         k++;
         if (k == 1) begin
            start = 1'b0;
            a     = W'($urandom);
            b     = W'($urandom);
         end
         if (busy) busy_cnt++;
         if (done) break;
      end
      chk({name, "_latency"}, k, W + 1);
      chk({name, "_busy_cycles"}, busy_cnt, W);
      chk({name, "_diff"}, diff, ed);
      chk({name, "_borrow"}, borrow_out, eb);
`ifdef SERIAL_SUB_OVF_EN
      chk({name, "_ovf"}, ovf, eo);
`endif
   endtask

   vec_t tbl[6];

   initial begin
      int k;
      int done_cnt;
      logic [W-1:0] ra, rb;
      vectors = 0;
      errors  = 0;

      tbl[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
      tbl[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
      tbl[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
      tbl[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
      tbl[4] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
      tbl[5] = '{8'h10, 8'h01, 8'h0F, 1'b0, 1'b0};

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_diff", diff, 0);
      chk("reset_borrow", borrow_out, 0);
`ifdef SERIAL_SUB_OVF_EN
      chk("reset_ovf", ovf, 0);
`endif
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // first edge after release with start=1 is accepted
      for (int i = 0; i < 6; i++) begin
         do_op(tbl[i].va, tbl[i].vb, tbl[i].exp_diff, tbl[i].exp_borrow, tbl[i].exp_ovf,
               $sformatf("tbl%0d", i));
      end

      // hold in IDLE
      repeat (4) @(negedge clk);
      chk("idle_hold_diff", diff, 8'h0F);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);

      // start pulse while busy is ignored
      start = 1'b1;
      a     = 8'h05;
      b     = 8'h03;
      done_cnt = 0;
      for (k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (k == 3) begin
            start = 1'b1;
            a     = 8'hAA;
            b     = 8'h11;
         end
         if (k == 4) start = 1'b0;
         if (done) begin
            done_cnt++;
            chk("busy_start_latency", k, W + 1);
            chk("busy_start_diff", diff, 8'h02);
            chk("busy_start_borrow", borrow_out, 0);
         end
      end
      chk("busy_start_done_count", done_cnt, 1);

      // back-to-back: second start issued in the DONE cycle
      do_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, "b2b_first");
      do_op(8'h09, 8'h04, 8'h05, 1'b0, 1'b0, "b2b_second");
      repeat (5) @(negedge clk);
      chk("b2b_hold_diff", diff, 8'h05);
      chk("b2b_hold_busy", busy, 0);

      // reset in the middle of SHIFT
      start = 1'b1;
      a     = 8'h07;
      b     = 8'h02;
      for (k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
      end
      chk("pre_reset_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_diff", diff, 0);
      @(negedge clk);
      rst = 1'b0;
      done_cnt = 0;
      for (k = 0; k < 15; k++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      chk("post_reset_no_done", done_cnt, 0);
      do_op(8'h07, 8'h02, 8'h05, 1'b0, 1'b0, "after_reset");

      // random operations against the arithmetic model, some with idle gaps
      for (int i = 0; i < 50; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
         do_op(ra, rb, m_diff(ra, rb), m_borrow(ra, rb), m_ovf(ra, rb), $sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port start  input  1  request to begin a subtraction; sampled on the rising edge of clk.
REQ-005 The block SHALL have port a  input  WIDTH  minuend, captured when start is accepted.
REQ-006 The block SHALL have port b  input  WIDTH  subtrahend, captured when start is accepted.
REQ-007 The block SHALL have port busy  output  1  high while an operation is in progress.
REQ-008 The block SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-009 The block SHALL have port diff  output  WIDTH  result, (a - b) mod 2^WIDTH.
REQ-010 The block SHALL have port borrow_out  output  1  final borrow; 1 exactly when unsigned a < b.

Function
REQ-011 The block SHALL implement a three-state FSM with states IDLE, SHIFT and DONE.
REQ-012 In IDLE or DONE, start=1 at an edge SHALL capture a and b, clear the borrow flip-flop and the bit counter, and enter SHIFT.
REQ-013 In SHIFT, each edge SHALL process one bit, LSB first: d = a_i XOR b_i XOR br, and br_next = (~a_i & b_i) | (~(a_i XOR b_i) & br).
REQ-014 Each processed bit d SHALL be shifted into diff from the MSB end, so that after WIDTH bits diff holds the full result in its natural bit order.
REQ-015 At the edge that processes bit WIDTH-1, the FSM SHALL go to DONE, and borrow_out SHALL load the final br.
REQ-016 done SHALL be high only while in DONE, which lasts exactly one cycle, and SHALL go high exactly WIDTH cycles after the accepting edge.
REQ-017 From DONE, the FSM SHALL go to SHIFT if start=1 (back-to-back operation) and to IDLE otherwise.
REQ-018 busy SHALL be high exactly while in SHIFT.
REQ-019 start SHALL be ignored while busy=1; the operand registers SHALL not change and the operation in progress SHALL continue undisturbed.
REQ-020 diff and borrow_out SHALL hold their last completed values through IDLE, and SHALL change only during SHIFT.
REQ-021 a and b MAY change freely after the accepting edge without affecting the result.

Reset
REQ-022 rst=1 SHALL immediately, without waiting for a clock edge, force state to IDLE and clear busy, done, diff, borrow_out, the counter, the borrow flip-flop and the operand registers.
REQ-023 Reset asserted mid-operation SHALL abandon the operation; no done pulse SHALL follow reset release.
REQ-024 The first edge after reset release with start=1 SHALL be accepted normally.

Configuration
REQ-025 With macro SERIAL_SUB_OVF_EN defined, the block SHALL add port ovf  output  1: the signed two's-complement overflow, equal to (a_msb != b_msb) & (diff_msb != a_msb).
REQ-026 ovf SHALL update at the same edge as borrow_out, follow the same hold rule, and reset to 0.
REQ-027 Without SERIAL_SUB_OVF_EN, port ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-028 Basic subtraction: a=0x05, b=0x03, one-cycle start -> busy for 8 cycles, then done pulse with diff=0x02, borrow_out=0.
REQ-029 Underflow: a=0x03, b=0x05 -> diff=0xFE, borrow_out=1; 0x00-0x00 -> diff=0x00, borrow_out=0; 0xFF-0xFF -> diff=0x00, borrow_out=0.
REQ-030 Overflow (with SERIAL_SUB_OVF_EN): a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, ovf=1; a=0x10, b=0x01 -> ovf=0.
REQ-031 Start while busy: accept 0x05-0x03, pulse start with a=0xAA, b=0x11 at cycle 3 -> result still 0x02 and exactly one done pulse.
REQ-032 Back-to-back and hold: start held high at done with a=0x09, b=0x04 -> second done 8 cycles later with diff=0x05; then start=0 -> diff stays 0x05 in IDLE.
REQ-033 Reset mid-operation: assert rst at cycle 4 of SHIFT -> busy, done and diff become 0 at once, with no done pulse after release; a following 0x07-0x02 yields diff=0x05.
